// File: rtl/mod_n_updown_counter_if.sv
// Control and status bundle for the modulo-N up/down counter.
// The bench or parent stage drives the master side; the counter sits on the slave side.
interface mod_n_updown_counter_if #(
   parameter int WIDTH = 4
);
   logic             en;
   logic             load;
   logic [WIDTH-1:0] Din;
   logic             up_down;
   logic             clr_err;
   logic [WIDTH-1:0] count;
   logic             tc;
   logic             carry;
   logic             borrow;
   logic             load_err;

   modport master (
      output en, load, Din, up_down, clr_err,
      input  count, tc, carry, borrow, load_err
   );

   modport slave (
      input  en, load, Din, up_down, clr_err,
      output count, tc, carry, borrow, load_err
   );
endinterface

// File: rtl/mod_n_updown_counter.sv
// Modulo-N up/down counter with synchronous load, wrap or saturate at the bounds,
// cascade carry/borrow pulses, a combinational terminal count and a sticky illegal-load flag.
module mod_n_updown_counter #(
   parameter int MODULUS  = 12,
   parameter int WIDTH    = 4,
   parameter int SATURATE = 0
) (
   input logic                  clk,
   input logic                  rst,
   mod_n_updown_counter_if.slave bus
);

   generate
      if (MODULUS < 2 || (2 ** WIDTH) < MODULUS) begin : g_bad_params
         $error("mod_n_updown_counter: MODULUS must be >= 2 and fit in WIDTH bits");
      end
   endgenerate

   localparam logic [WIDTH:0] MAX_EXT = (WIDTH + 1)'(MODULUS - 1);
   localparam logic [WIDTH:0] MOD_EXT = (WIDTH + 1)'(MODULUS);
   localparam bit             WRAP    = (SATURATE == 0);

   logic             active_reg;
   logic [WIDTH-1:0] count_reg, count_next;
   logic             carry_reg, carry_next;
   logic             borrow_reg, borrow_next;
   logic             err_reg, err_next;

   logic [WIDTH:0] inc_ext;
   logic [WIDTH:0] dec_ext;
   logic [WIDTH:0] din_ext;
   logic           at_max;
   logic           at_zero;
   logic           din_legal;

   // One extra bit lets the bound tests read straight off the adder results.
   assign inc_ext   = {1'b0, count_reg} + 1'b1;
   assign dec_ext   = {1'b0, count_reg} - 1'b1;
   assign din_ext   = {1'b0, bus.Din};
   assign at_max    = (inc_ext == MOD_EXT);
   assign at_zero   = dec_ext[WIDTH];
   assign din_legal = (din_ext <= MAX_EXT);

   always_comb begin
      count_next  = count_reg;
      carry_next  = 1'b0;
      borrow_next = 1'b0;
      err_next    = err_reg;
      if (active_reg) begin
         if (bus.load) begin
            if (din_legal) begin
               count_next = bus.Din;
            end
         end else if (bus.en) begin
            if (bus.up_down) begin
               if (!at_max) begin
                  count_next = inc_ext[WIDTH-1:0];
               end else if (WRAP) begin
                  count_next = '0;
                  carry_next = 1'b1;
               end
            end else begin
               if (!at_zero) begin
                  count_next = dec_ext[WIDTH-1:0];
               end else if (WRAP) begin
                  count_next  = MAX_EXT[WIDTH-1:0];
                  borrow_next = 1'b1;
               end
            end
         end
         // An illegal load on the same edge as a clear leaves the flag set.
         if (bus.load && !din_legal) begin
            err_next = 1'b1;
         end else if (bus.clr_err) begin
            err_next = 1'b0;
         end
      end
   end

   // active_reg delays the first update to the second edge after reset release.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         active_reg <= 1'b0;
         count_reg  <= '0;
         carry_reg  <= 1'b0;
         borrow_reg <= 1'b0;
         err_reg    <= 1'b0;
      end else begin
         active_reg <= 1'b1;
         count_reg  <= count_next;
         carry_reg  <= carry_next;
         borrow_reg <= borrow_next;
         err_reg    <= err_next;
      end
   end

   assign bus.count    = count_reg;
   assign bus.carry    = carry_reg;
   assign bus.borrow   = borrow_reg;
   assign bus.load_err = err_reg;
   assign bus.tc       = bus.en && ((bus.up_down && at_max) || (!bus.up_down && at_zero));

endmodule

// File: tb/tb_mod_n_updown_counter.sv
// Randomised and directed bench for the modulo-N counter: wrap and saturate instances
// share one stimulus stream and an arithmetic reference model; a mod-10 pair is cascaded.
module tb_mod_n_updown_counter;

   localparam int M = 12;

   logic clk;
   logic rst;

   logic       en, load, up_down, clr_err;
   logic [3:0] din;
   logic       cas_en;

   int vectors     = 0;
   int miscompares = 0;

   // Reference model state: index 0 = wrapping instance, 1 = saturating instance.
   int m_cnt    [2];
   int m_carry  [2];
   int m_borrow [2];
   int m_err    [2];
   bit m_sync;

   mod_n_updown_counter_if #(.WIDTH(4)) bus_w ();
   mod_n_updown_counter_if #(.WIDTH(4)) bus_s ();
   mod_n_updown_counter_if #(.WIDTH(4)) bus_lo ();
   mod_n_updown_counter_if #(.WIDTH(4)) bus_hi ();

   assign bus_w.en = en;       assign bus_s.en = en;
   assign bus_w.load = load;   assign bus_s.load = load;
   assign bus_w.Din = din;     assign bus_s.Din = din;
   assign bus_w.up_down = up_down; assign bus_s.up_down = up_down;
   assign bus_w.clr_err = clr_err; assign bus_s.clr_err = clr_err;

   assign bus_lo.en = cas_en;       assign bus_hi.en = bus_lo.tc;
   assign bus_lo.load = 1'b0;       assign bus_hi.load = 1'b0;
   assign bus_lo.Din = 4'd0;        assign bus_hi.Din = 4'd0;
   assign bus_lo.up_down = 1'b1;    assign bus_hi.up_down = 1'b1;
   assign bus_lo.clr_err = 1'b0;    assign bus_hi.clr_err = 1'b0;

   mod_n_updown_counter #(.MODULUS(12), .WIDTH(4), .SATURATE(0)) u_wrap (.clk(clk), .rst(rst), .bus(bus_w));
   mod_n_updown_counter #(.MODULUS(12), .WIDTH(4), .SATURATE(1)) u_sat  (.clk(clk), .rst(rst), .bus(bus_s));
   mod_n_updown_counter #(.MODULUS(10), .WIDTH(4), .SATURATE(0)) u_lo   (.clk(clk), .rst(rst), .bus(bus_lo));
   mod_n_updown_counter #(.MODULUS(10), .WIDTH(4), .SATURATE(0)) u_hi   (.clk(clk), .rst(rst), .bus(bus_hi));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic e, input logic l, input int d, input logic ud, input logic c);
      en = e; load = l; din = 4'(d); up_down = ud; clr_err = c;
   endtask

   function automatic int model_tc(input int s);
      if (!en) return 0;
      return up_down ? int'(m_cnt[s] == M - 1) : int'(m_cnt[s] == 0);
   endfunction

   task automatic model_zero();
      for (int s = 0; s < 2; s++) begin
         m_cnt[s] = 0; m_carry[s] = 0; m_borrow[s] = 0; m_err[s] = 0;
      end
      m_sync = 1'b0;
   endtask

   task automatic model_edge();
      int nxt;
      if (!m_sync) begin
         m_sync = 1'b1;
         return;
      end
      for (int s = 0; s < 2; s++) begin
         m_carry[s] = 0;
         m_borrow[s] = 0;
         if (load) begin
            if (int'(din) < M) m_cnt[s] = int'(din);
         end else if (en) begin
            nxt = up_down ? m_cnt[s] + 1 : m_cnt[s] - 1;
            if (nxt >= M) begin
               if (s == 0) begin m_cnt[s] = nxt - M; m_carry[s] = 1; end
            end else if (nxt < 0) begin
               if (s == 0) begin m_cnt[s] = nxt + M; m_borrow[s] = 1; end
            end else begin
               m_cnt[s] = nxt;
            end
         end
         if (load && int'(din) >= M) m_err[s] = 1;
         else if (clr_err) m_err[s] = 0;
      end
   endtask

   task automatic check_outputs(input string pfx);
      check({pfx, "_count_w"},  bus_w.count,    m_cnt[0]);
      check({pfx, "_carry_w"},  bus_w.carry,    m_carry[0]);
      check({pfx, "_borrow_w"}, bus_w.borrow,   m_borrow[0]);
      check({pfx, "_err_w"},    bus_w.load_err, m_err[0]);
      check({pfx, "_count_s"},  bus_s.count,    m_cnt[1]);
      check({pfx, "_carry_s"},  bus_s.carry,    m_carry[1]);
      check({pfx, "_borrow_s"}, bus_s.borrow,   m_borrow[1]);
      check({pfx, "_err_s"},    bus_s.load_err, m_err[1]);
   endtask

   // Inputs are already set; check tc before the edge, state after it.
   task automatic step(input string pfx);
      #1;
      check({pfx, "_tc_w"}, bus_w.tc, model_tc(0));
      check({pfx, "_tc_s"}, bus_s.tc, model_tc(1));
      @(posedge clk);
      model_edge();
      #1;
      check_outputs(pfx);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      #1;
      check("rst_async_count", bus_w.count, 0);
      check("rst_async_carry", bus_w.carry, 0);
      check("rst_async_borrow", bus_w.borrow, 0);
      check("rst_async_err", bus_w.load_err, 0);
      model_zero();
      check_outputs("rst_async");
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   initial begin
      int n;
      int pulses;
      rst = 1'b0;
      cas_en = 1'b0;
      drive(0, 0, 0, 1, 0);
      model_zero();
      #2;
      check("por_count", bus_w.count, 0);
      check("por_err", bus_w.load_err, 0);
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b1;

      drive(1, 0, 0, 1, 0);
      step("sync1");
      check("sync_first_edge_hold", bus_w.count, 0);
      step("sync2");
      check("sync_second_edge_inc", bus_w.count, 1);

      // Mid-count reset with the error flag set.
      drive(0, 1, 7, 1, 0);  step("ld7");
      drive(0, 1, 13, 1, 0); step("ld13");
      check("err_before_rst", bus_w.load_err, 1);
      drive(1, 0, 0, 1, 0);
      do_reset();
      step("rel1");
      step("rel2");
      check("after_rel_inc", bus_w.count, 1);

      // Up wrap.
      drive(0, 1, 10, 1, 0); step("ldup");
      drive(1, 0, 0, 1, 0);
      step("up1"); check("up_to_11", bus_w.count, 11);
      check("tc_at_11", bus_w.tc, 1);
      step("up2"); check("up_wrap_0", bus_w.count, 0); check("up_carry", bus_w.carry, 1);
      step("up3"); check("up_to_1", bus_w.count, 1); check("up_carry_gone", bus_w.carry, 0);

      // Down wrap.
      drive(0, 1, 1, 0, 0); step("lddn");
      drive(1, 0, 0, 0, 0);
      step("dn1"); check("dn_to_0", bus_w.count, 0); check("tc_at_0", bus_w.tc, 1);
      step("dn2"); check("dn_wrap_11", bus_w.count, 11); check("dn_borrow", bus_w.borrow, 1);
      step("dn3"); check("dn_to_10", bus_w.count, 10);

      // Illegal load and clear.
      drive(0, 1, 5, 1, 0);  step("ld5");
      drive(0, 1, 13, 1, 0); step("ill1");
      check("ill_count_kept", bus_w.count, 5); check("ill_err_set", bus_w.load_err, 1);
      drive(0, 0, 0, 1, 0);  step("ill_hold"); check("ill_err_sticky", bus_w.load_err, 1);
      drive(0, 0, 0, 1, 1);  step("clr");      check("clr_err", bus_w.load_err, 0);
      drive(0, 1, 13, 1, 1); step("ill_clr");  check("set_beats_clr", bus_w.load_err, 1);
      drive(0, 0, 0, 1, 1);  step("clr2");

      // Priority and saturation.
      drive(1, 1, 3, 1, 0);  step("prio"); check("load_beats_en", bus_w.count, 3);
      drive(0, 1, 11, 1, 0); step("ld11");
      drive(1, 0, 0, 1, 0);
      for (int i = 0; i < 4; i++) begin
         step("sat_up");
         check("sat_hold_11", bus_s.count, 11);
         check("sat_no_carry", bus_s.carry, 0);
      end
      drive(0, 1, 0, 0, 0);  step("ld0");
      drive(1, 0, 0, 0, 0);  step("sat_dn"); check("sat_hold_0", bus_s.count, 0);

      // Randomised traffic against the model.
      for (int i = 0; i < 400; i++) begin
         drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0),
               int'($urandom_range(0, 15)), 1'($urandom), ($urandom_range(0, 15) == 0));
         if ($urandom_range(0, 99) == 0) do_reset();
         step("rnd");
      end

      // Cascade of two mod-10 stages.
      drive(0, 0, 0, 1, 0);
      step("pre_cas");
      step("pre_cas");
      check("cas_lo_start", bus_lo.count, 0);
      check("cas_hi_start", bus_hi.count, 0);
      cas_en = 1'b1;
      pulses = 0;
      for (n = 1; n <= 100; n++) begin
         @(posedge clk);
         #1;
         check("cas_lo", bus_lo.count, n % 10);
         check("cas_hi", bus_hi.count, (n / 10) % 10);
         check("cas_lo_carry", bus_lo.carry, int'(n % 10 == 0));
         if (bus_hi.carry) pulses++;
      end
      cas_en = 1'b0;
      check("cas_lo_end", bus_lo.count, 0);
      check("cas_hi_end", bus_hi.count, 0);
      check("cas_hi_pulses", pulses, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
